fifo_ptr_ctrl: RTL and testbench

Single-clock FIFO pointer controller that sequences the write and read gray-code pointer counters of the FIFO.
- Accepts write/read requests and gates them against full/empty.
- Drives RAM write/read enables and addresses.
- Produces registered status flags, occupancy count, and error pulses.
- Sits between the requester interfaces and the dual-port RAM. Its gray pointer outputs feed the CDC variant of the FIFO.

---
 rtl/fifo_ptr_ctrl.sv | 139 +++++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller: gated RAM strobes, gray-coded
// write/read pointers, registered status flags, occupancy and error pulses.

// Gray counter: binary core plus a registered gray copy of the next value.
module fifo_gray_ctr #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] bin,
  output logic [W-1:0] bin_next_c,
  output logic [W-1:0] gray
);

  always_comb begin
    bin_next_c = bin;
    if (clr) begin
      bin_next_c = '0;
    end else if (en) begin
      bin_next_c = bin + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next_c;
      gray <= bin_next_c ^ (bin_next_c >> 1);
    end
  end

endmodule

module fifo_ptr_ctrl #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_TH = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] wr_ptr_bin;
  logic [PTR_W-1:0] rd_ptr_bin;
  logic [PTR_W-1:0] wr_ptr_next_c;
  logic [PTR_W-1:0] rd_ptr_next_c;

  logic [PTR_W-1:0] count_next_c;
  logic             full_next_c;
  logic             empty_next_c;
  logic             almost_full_next_c;
  logic             almost_empty_next_c;
  logic             overflow_next_c;
  logic             underflow_next_c;

  // Flush wins over both requests; strobes are gated on the registered flags.
  assign wr_en = wr_req & ~full  & ~flush;
  assign rd_en = rd_req & ~empty & ~flush;

  assign wr_addr = wr_ptr_bin[ADDR_W-1:0];
  assign rd_addr = rd_ptr_bin[ADDR_W-1:0];

  fifo_gray_ctr #(.W(PTR_W)) u_wr_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush),
    .en         (wr_en),
    .bin        (wr_ptr_bin),
    .bin_next_c (wr_ptr_next_c),
    .gray       (wr_ptr_gray)
  );

  fifo_gray_ctr #(.W(PTR_W)) u_rd_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush),
    .en         (rd_en),
    .bin        (rd_ptr_bin),
    .bin_next_c (rd_ptr_next_c),
    .gray       (rd_ptr_gray)
  );

  // Status derived from next-state pointers so flags track the access with no lag.
  always_comb begin
    count_next_c        = wr_ptr_next_c - rd_ptr_next_c;
    empty_next_c        = (wr_ptr_next_c == rd_ptr_next_c);
    full_next_c         = (wr_ptr_next_c[ADDR_W] != rd_ptr_next_c[ADDR_W]) &&
                          (wr_ptr_next_c[ADDR_W-1:0] == rd_ptr_next_c[ADDR_W-1:0]);
    almost_full_next_c  = (count_next_c >= AF_TH);
    almost_empty_next_c = (count_next_c <= AE_TH);
    overflow_next_c     = wr_req & full  & ~flush;
    underflow_next_c    = rd_req & empty & ~flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_next_c;
      full         <= full_next_c;
      empty        <= empty_next_c;
      almost_full  <= almost_full_next_c;
      almost_empty <= almost_empty_next_c;
      overflow     <= overflow_next_c;
      underflow    <= underflow_next_c;
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl: a reference model pushes expected
// post-edge state into a queue, popped and compared after each clock.
module tb_fifo_ptr_ctrl;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AF     = 14;
  localparam int unsigned AE     = 2;

  logic clk, rst, flush, wr_req, rd_req;
  logic wr_en, rd_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [ADDR_W:0] wr_ptr_gray, rd_ptr_gray, count;
  logic full, empty, almost_full, almost_empty, overflow, underflow;

  fifo_ptr_ctrl #(.ADDR_W(ADDR_W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_req(wr_req), .rd_req(rd_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] wg;
    logic [4:0] rg;
    logic [4:0] cnt;
    logic [3:0] wa;
    logic [3:0] ra;
    logic       fl;
    logic       em;
    logic       af;
    logic       ae;
    logic       ov;
    logic       uf;
    logic       wen;
    logic       ren;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [4:0] m_wp, m_rp;
  logic       m_full, m_empty;
  logic [4:0] prev_wg, prev_rg;

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_wp = '0; m_rp = '0; m_full = 1'b0; m_empty = 1'b1;
    prev_wg = '0; prev_rg = '0;
  endtask

  // One clock: drive, check strobes, push expectation, clock, pop and compare.
  task automatic step(input logic w, input logic r, input logic f);
    exp_t e;
    logic [4:0] c;
    logic [4:0] wg_now, rg_now;
    wr_req = w; rd_req = r; flush = f;
    #1;
    e.wen = w & ~m_full  & ~f;
    e.ren = r & ~m_empty & ~f;
    chk("wr_en", 32'(wr_en), 32'(e.wen));
    chk("rd_en", 32'(rd_en), 32'(e.ren));
    chk("wr_addr", 32'(wr_addr), 32'(m_wp[3:0]));
    chk("rd_addr", 32'(rd_addr), 32'(m_rp[3:0]));
    e.ov = w & m_full  & ~f;
    e.uf = r & m_empty & ~f;
    if (f) begin
      m_wp = '0; m_rp = '0;
    end else begin
      if (e.wen) m_wp = m_wp + 5'd1;
      if (e.ren) m_rp = m_rp + 5'd1;
    end
    c = m_wp - m_rp;
    m_full  = (32'(c) == DEPTH);
    m_empty = (c == 5'd0);
    e.wg = to_gray(m_wp); e.rg = to_gray(m_rp);
    e.cnt = c; e.wa = m_wp[3:0]; e.ra = m_rp[3:0];
    e.fl = m_full; e.em = m_empty;
    e.af = (32'(c) >= AF); e.ae = (32'(c) <= AE);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(e.wg));
    chk("rd_ptr_gray", 32'(rd_ptr_gray), 32'(e.rg));
    chk("count", 32'(count), 32'(e.cnt));
    chk("full", 32'(full), 32'(e.fl));
    chk("empty", 32'(empty), 32'(e.em));
    chk("almost_full", 32'(almost_full), 32'(e.af));
    chk("almost_empty", 32'(almost_empty), 32'(e.ae));
    chk("overflow", 32'(overflow), 32'(e.ov));
    chk("underflow", 32'(underflow), 32'(e.uf));
    chk("wr_addr_post", 32'(wr_addr), 32'(e.wa));
    chk("rd_addr_post", 32'(rd_addr), 32'(e.ra));
    wg_now = wr_ptr_gray; rg_now = rd_ptr_gray;
    if (!f) begin
      chk("wr_gray_1bit", 32'($countones(wg_now ^ prev_wg)), 32'(e.wen ? 1 : 0));
      chk("rd_gray_1bit", 32'($countones(rg_now ^ prev_rg)), 32'(e.ren ? 1 : 0));
    end
    prev_wg = wg_now; prev_rg = rg_now;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_af"}, 32'(almost_full), 32'd0);
    chk({tag, "_wg"}, 32'(wr_ptr_gray), 32'd0);
    chk({tag, "_rg"}, 32'(rd_ptr_gray), 32'd0);
    chk({tag, "_ov"}, 32'(overflow), 32'd0);
    chk({tag, "_uf"}, 32'(underflow), 32'd0);
    chk({tag, "_wa"}, 32'(wr_addr), 32'd0);
  endtask

  logic [4:0] gray_seq [5];
  logic [4:0] wg_before;
  logic [4:0] wrap_start;

  initial begin
    gray_seq[0] = 5'b00001; gray_seq[1] = 5'b00011; gray_seq[2] = 5'b00010;
    gray_seq[3] = 5'b00110; gray_seq[4] = 5'b00111;
    rst = 1'b1; flush = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_state("reset");

    // Fill to full, checking the literal gray sequence on the first writes
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i < 5) chk("gray_seq", 32'(wr_ptr_gray), 32'(gray_seq[i]));
    end
    chk("full_after_fill", 32'(full), 32'd1);
    chk("count_after_fill", 32'(count), 32'd16);

    // Overflow at full, then pulse must drop on an idle cycle
    wg_before = wr_ptr_gray;
    step(1'b1, 1'b0, 1'b0);
    chk("ovf_ptr_hold", 32'(wr_ptr_gray), 32'(wg_before));
    step(1'b0, 1'b0, 1'b0);

    // Simultaneous at full: read wins
    step(1'b1, 1'b1, 1'b0);

    // Drain to empty, then underflow and simultaneous at empty
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("count_simul_empty", 32'(count), 32'd1);

    // Wrap: 40 writes interleaved with reads, occupancy 1..2
    wrap_start = m_wp;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) begin
        step(1'b1, 1'b1, 1'b0);
      end else begin
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
      end
    end
    chk("wrap_wp", 32'(m_wp), 32'(5'(wrap_start + 5'd8)));

    // Flush at count 9 with a write request
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    chk("count_pre_flush", 32'(count), 32'd9);
    step(1'b1, 1'b0, 1'b1);
    chk_reset_state("flush");

    // Flush while full with both requests: no error pulses
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle at count 9
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);
    wr_req = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
